// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder controller built around a single one-bit full adder cell
// Operands are latched on start and consumed LSB first, one bit per cycle; result is published only on completion.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_s;
  logic fa_c;

  full_adder u_fa (
    .i_a (a_q[0]),
    .i_b (b_q[0]),
    .i_c (carry_q),
    .o_s (fa_s),
    .o_c (fa_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          state_d = ADD;
          a_d     = i_a;
          b_d     = i_b;
          carry_d = i_cin;
          res_d   = '0;
          cnt_d   = '0;
        end
      end
      ADD: begin
        if (i_abort) begin
          state_d = IDLE;
        end else begin
          a_d     = a_q >> 1;
          b_d     = b_q >> 1;
          res_d   = {fa_s, res_q[WIDTH-1:1]};
          carry_d = fa_c;
          cnt_d   = cnt_q + 1'b1;
          // The visible result only changes here, so partial sums never leak out.
          if (cnt_q == LAST_BIT) begin
            state_d = DONE;
            sum_d   = {fa_s, res_q[WIDTH-1:1]};
            cout_d  = fa_c;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_ready = (state_q == IDLE);
  assign o_busy  = (state_q == ADD);
  assign o_done  = (state_q == DONE);
  assign o_sum   = sum_q;
  assign o_cout  = cout_q;

endmodule
